uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: the reader for the existing 8N1 uart_tx frame format (start bit, 8 data bits LSB-first, stop bit).
- Synchronises the asynchronous rx line, validates the start bit, and majority-votes each bit at mid-bit.
- Checks the stop bit and delivers bytes on a ready/valid handshake, with framing and overrun reporting.
- Sits between the pad-side rx pin and the byte consumer in top-level integrations.

Parameters:
- clk_frq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16; must be a power of 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accept; transfer occurs when rx_valid and rx_ready are both 1 on a clk edge.
- frame_err  output  1  one-clk pulse: stop bit sampled 0.
- overrun  output  1  one-clk pulse: byte completed while rx_valid was still 1.
- parity_err  output  1  one-clk pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; all state updates on posedge clk.
- Reset values (rst=0 at a clk edge): rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0, state=IDLE. Synchroniser flops preset to 1. Tick counter=0.
- Reset mid-frame: aborts the frame with no valid and no error pulse.
- Synchroniser: 2-flop on rx; all logic uses the synced value rxs. This adds 2 clk of latency.
- Tick: TDIV = clk_frq/(baud_rate*16), integer truncated, minimum 1. Tick counter counts 0..TDIV-1 and pulses tick at wrap. Counter is cleared on start-edge detect so sampling phase aligns to the edge.
- Bit phase: sample counter sc counts 0..15 per bit on ticks. Samples are taken at sc = 7, 8, 9; the bit value is the majority of the three, decided at sc=9.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: on rxs 1->0, go to START with sc=0 and tick counter cleared.
- START: at sc=9, if majority=1 (glitch) go to IDLE with no outputs; else go to DATA with bit index 0.
- DATA: at sc=9, shift the majority bit into a shift register LSB-first. After bit index 7, go to STOP (or PARITY when the macro is defined).
- STOP: at sc=9, if majority=1:
  - if rx_valid=0, load rx_data and set rx_valid next clk;
  - if rx_valid=1, pulse overrun and drop the new byte (old byte retained);
  - go to IDLE immediately (no wait for end of stop bit), so back-to-back frames are caught.
- STOP with majority=0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: remain until rxs=1, then go to IDLE. This absorbs break conditions.
- Handshake: rx_valid clears on the edge where rx_valid & rx_ready. If a new byte lands on that same edge, rx_valid stays 1 with the new data and no overrun is raised.
- Latency: rx_valid rises 1 clk after the stop bit's sc=9 tick edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit. On mismatch, pulse parity_err, discard the byte, and still check the stop bit (frame_err may pulse in addition).
- Undefined: no PARITY state; parity_err is constant 0.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum;
  - OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
- Sub-module uart_baud_tick: parameterised TDIV divider with sync clear, producing a one-clk tick pulse.

Test Plan:
- All scenarios use clk_frq=1600000, baud_rate=10000 (TDIV=10, 160 clk/bit), with rx_ready held 1 unless noted.
- Frame 0xA5, stop=1 -> rx_data=0xA5, rx_valid for 1 clk, frame_err=0, busy falls at stop mid-bit.
- rx low for 40 clk (4 ticks), then high -> no rx_valid, busy returns 0 within 10 ticks, next frame 0x3C received correctly.
- Frame 0x81 with stop=0, rx held low 400 clk, then high -> one frame_err pulse, no rx_valid; next frame 0x11 received.
- rx_ready=0; frames 0x3C then 0xC3 back-to-back -> rx_data stays 0x3C, one overrun pulse at the second stop; after rx_ready=1, rx_valid clears.
- rst=0 for 2 clk during data bit 4 of 0xFF -> all outputs 0, busy=0; following frame 0x5A received, no errors.
- With UART_RX_PARITY_EN: 0x07 with parity=1 -> accepted; 0x07 with parity=0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
// UART_RX_PARITY_EN adds the even-parity state to rx_state_t.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-side and line-side signals of uart_rx_os.
// master: the receiver; slave: the line driver / byte consumer.
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, parity_err, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, parity_err, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..TDIV-1 and pulses o_tick at wrap.
// i_clr restarts the count so the sample phase follows the start edge.
module uart_baud_tick #(
  parameter int unsigned TDIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned CntW = (TDIV > 1) ? $clog2(TDIV) : 1;

  logic [CntW-1:0] r_cnt;

  assign o_tick = (r_cnt == CntW'(TDIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote at mid-bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_os #(
  parameter int unsigned clk_frq    = 1000000,
  parameter int unsigned baud_rate  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic          clk,
  input logic          rst,
  uart_rx_os_if.master bus
);
  import uart_pkg::*;

  localparam int unsigned TDIV_RAW = clk_frq / (baud_rate * OVERSAMPLE);
  localparam int unsigned TDIV     = (TDIV_RAW < 1) ? 1 : TDIV_RAW;

  rx_state_t  r_state, w_state_d;
  logic       r_sync1, r_rxs, r_rxs_prev;
  logic [3:0] r_sc, w_sc_d;
  logic [2:0] r_bit_idx, w_bit_idx_d;
  logic [7:0] r_shift, w_shift_d;
  logic [7:0] r_data, w_data_d;
  logic       r_valid, w_valid_d;
  logic       r_ferr, w_ferr_d;
  logic       r_ovr, w_ovr_d;
  logic       r_s_lo, r_s_mid;
  logic       w_tick, w_tick_clr, w_decide, w_maj, w_par_ok;
`ifdef UART_RX_PARITY_EN
  logic       r_perr, w_perr_d, r_perr_flag, w_perr_flag_d;
`endif

  uart_baud_tick #(.TDIV(TDIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  assign w_decide = w_tick && (r_sc == 4'(SAMPLE_HI));
  assign w_maj    = maj3(r_s_lo, r_s_mid, r_rxs);
`ifdef UART_RX_PARITY_EN
  assign w_par_ok = !r_perr_flag;
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_sc_d      = r_sc;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_data_d    = r_data;
    w_valid_d   = r_valid;
    w_ferr_d    = 1'b0;
    w_ovr_d     = 1'b0;
    w_tick_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_d      = 1'b0;
    w_perr_flag_d = r_perr_flag;
`endif
    if (r_valid && bus.rx_ready) w_valid_d = 1'b0;
    if (w_tick) w_sc_d = r_sc + 4'd1;

    unique case (r_state)
      StIdle: begin
        if (r_rxs_prev && !r_rxs) begin
          w_state_d  = StStart;
          w_sc_d     = 4'd0;
          w_tick_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_perr_flag_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (w_decide) begin
          w_state_d   = w_maj ? StIdle : StData;
          w_bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (w_decide) begin
          w_shift_d   = {w_maj, r_shift[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_decide) begin
          if (w_maj != ^r_shift) begin
            w_perr_d      = 1'b1;
            w_perr_flag_d = 1'b1;
          end
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (w_decide) begin
          if (w_maj) begin
            // Returning to idle at mid-stop lets a back-to-back start edge be caught.
            w_state_d = StIdle;
            if (w_par_ok) begin
              if (r_valid && !bus.rx_ready) begin
                w_ovr_d = 1'b1;
              end else begin
                w_data_d  = r_shift;
                w_valid_d = 1'b1;
              end
            end
          end else begin
            w_ferr_d  = 1'b1;
            w_state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (r_rxs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_state    <= StIdle;
      r_sc       <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_data     <= 8'd0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_s_lo     <= 1'b1;
      r_s_mid    <= 1'b1;
    end else begin
      r_sync1    <= bus.rx;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
      r_state    <= w_state_d;
      r_sc       <= w_sc_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
      r_data     <= w_data_d;
      r_valid    <= w_valid_d;
      r_ferr     <= w_ferr_d;
      r_ovr      <= w_ovr_d;
      if (w_tick && r_sc == 4'(SAMPLE_LO))  r_s_lo  <= r_rxs;
      if (w_tick && r_sc == 4'(SAMPLE_MID)) r_s_mid <= r_rxs;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perr      <= 1'b0;
      r_perr_flag <= 1'b0;
    end else begin
      r_perr      <= w_perr_d;
      r_perr_flag <= w_perr_flag_d;
    end
  end
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at 160 clk/bit (TDIV=10).
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;
  localparam int unsigned ClkFrq = 1600000;
  localparam int unsigned Baud   = 10000;
  localparam int          BitClk = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, vhi_cnt = 0;

  uart_rx_os_if bus ();

  uart_rx_os #(
    .clk_frq    (ClkFrq),
    .baud_rate  (Baud),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: record delivered bytes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_err)  ferr_cnt++;
      if (bus.overrun)    ovr_cnt++;
      if (bus.parity_err) perr_cnt++;
      if (bus.rx_valid)   vhi_cnt++;
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par_mode: 0 no parity bit, 1 correct even parity, 2 wrong parity.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks,
                            input int par_mode);
    bus.rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clk(BitClk);
    end
    if (par_mode != 0) begin
      bus.rx = (par_mode == 1) ? ^d : ~^d;
      wait_clk(BitClk);
    end
    bus.rx = stop;
    wait_clk(stop_clks);
    bus.rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clk(4);
    n_vec++; if (bus.rx_data !== 8'h00) begin n_err++;
      $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    n_vec++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0 || bus.parity_err !== 1'b0)
      begin n_err++; $display("FAIL reset_err_flags got=%b%b%b want=000",
        bus.frame_err, bus.overrun, bus.parity_err); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy got=%b want=0", bus.busy); end
    rst = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_basic();
    logic [7:0] g, e;
    int v0, f0;
    v0 = vhi_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 90, 0);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++;
      $display("FAIL a5_busy_before_mid got=%b want=1", bus.busy); end
    wait_clk(30);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++;
      $display("FAIL a5_busy_after_mid got=%b want=0", bus.busy); end
    n_vec++; if (vhi_cnt - v0 !== 1) begin n_err++;
      $display("FAIL a5_valid_cycles got=%0d want=1", vhi_cnt - v0); end
    n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++;
      $display("FAIL a5_frame_err got=%0d want=0", ferr_cnt - f0); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL a5_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL a5_data got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL a5_missing got=%0d want=0 pending", exp_q.size()); exp_q.delete(); end
    wait_clk(100);
  endtask

  task automatic test_glitch();
    logic [7:0] g, e;
    bus.rx = 1'b0;
    wait_clk(20);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++;
      $display("FAIL glitch_busy_start got=%b want=1", bus.busy); end
    wait_clk(20);
    bus.rx = 1'b1;
    wait_clk(70);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++;
      $display("FAIL glitch_busy_clear got=%b want=0", bus.busy); end
    n_vec++; if (got_q.size() !== 0) begin n_err++;
      $display("FAIL glitch_no_byte got=%0d want=0", got_q.size()); end
    wait_clk(100);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BitClk, 0);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL glitch_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL glitch_next got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL glitch_missing got=%0d want=0 pending", exp_q.size()); exp_q.delete(); end
    wait_clk(100);
  endtask

  task automatic test_frame_err();
    logic [7:0] g, e;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 400, 0);
    wait_clk(20);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++;
      $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt - f0); end
    n_vec++; if (got_q.size() !== 0) begin n_err++;
      $display("FAIL ferr_no_byte got=%0d want=0", got_q.size()); got_q.delete(); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++;
      $display("FAIL ferr_busy got=%b want=0", bus.busy); end
    wait_clk(100);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BitClk, 0);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL ferr_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL ferr_next got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL ferr_missing got=%0d want=0 pending", exp_q.size()); exp_q.delete(); end
    wait_clk(100);
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e;
    int o0;
    o0 = ovr_cnt;
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BitClk, 0);
    send_frame(8'hC3, 1'b1, BitClk, 0);
    n_vec++; if (ovr_cnt - o0 !== 1) begin n_err++;
      $display("FAIL ovr_pulses got=%0d want=1", ovr_cnt - o0); end
    n_vec++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin n_err++;
      $display("FAIL ovr_held got=%b/%h want=1/3c", bus.rx_valid, bus.rx_data); end
    bus.rx_ready = 1'b1;
    wait_clk(3);
    n_vec++; if (bus.rx_valid !== 1'b0) begin n_err++;
      $display("FAIL ovr_valid_clear got=%b want=0", bus.rx_valid); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL ovr_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL ovr_data got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL ovr_missing got=%0d want=0 pending", exp_q.size()); exp_q.delete(); end
    wait_clk(100);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] g, e;
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    bus.rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 4; i++) begin bus.rx = 1'b1; wait_clk(BitClk); end
    wait_clk(80);
    rst = 1'b0;
    wait_clk(2);
    n_vec++; if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.parity_err,
                  bus.busy} !== 13'd0) begin n_err++;
      $display("FAIL midrst_outputs got=%h/%b%b%b%b/%b want=00/0000/0", bus.rx_data,
               bus.rx_valid, bus.frame_err, bus.overrun, bus.parity_err, bus.busy); end
    rst = 1'b1;
    wait_clk(78 + 4 * BitClk);
    n_vec++; if (got_q.size() !== 0 || ferr_cnt != f0 || ovr_cnt != o0) begin n_err++;
      $display("FAIL midrst_quiet got=%0d/%0d/%0d want=0/0/0", got_q.size(),
               ferr_cnt - f0, ovr_cnt - o0); got_q.delete(); end
    wait_clk(100);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BitClk, 0);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL midrst_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL midrst_next got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0 || ferr_cnt != f0) begin n_err++;
      $display("FAIL midrst_missing got=%0d/%0d want=0/0", exp_q.size(), ferr_cnt - f0);
      exp_q.delete(); end
    wait_clk(100);
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    logic [7:0] g, e;
    int p0, f0;
    p0 = perr_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, BitClk, 1);
    wait_clk(100);
    send_frame(8'h07, 1'b1, BitClk, 2);
    n_vec++; if (perr_cnt - p0 !== 1) begin n_err++;
      $display("FAIL par_pulses got=%0d want=1", perr_cnt - p0); end
    n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++;
      $display("FAIL par_frame_err got=%0d want=0", ferr_cnt - f0); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL par_extra got=%h want=none", g); end
      else begin e = exp_q.pop_front();
        if (g !== e) begin n_err++; $display("FAIL par_data got=%h want=%h", g, e); end end
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL par_missing got=%0d want=0 pending", exp_q.size()); exp_q.delete(); end
`else
    n_vec++; if (perr_cnt !== 0) begin n_err++;
      $display("FAIL parity_tied got=%0d pulses want=0", perr_cnt); end
`endif
    wait_clk(100);
  endtask

  initial begin
    bus.rx       = 1'b1;
    bus.rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
